spi_slave: RTL

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave_pkg.sv | 39 +++
 rtl/spi_slave_if.sv | 16 +
 rtl/spi_slave_sync_bits.sv | 34 +++
 rtl/spi_slave.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_slave_pkg : register map, bit positions, FSM states and fill    |
// | value shared by the SPI slave and the companion spi_master.         |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
package spi_slave_pkg;

  localparam logic [3:0] ADDR_STATUS   = 4'h0;
  localparam logic [3:0] ADDR_DATA_OUT = 4'h1;
  localparam logic [3:0] ADDR_DATA_IN  = 4'h2;
  localparam logic [3:0] ADDR_CTRL     = 4'h3;

  localparam int STAT_SELECTED = 0;
  localparam int STAT_RX_FULL  = 1;
  localparam int STAT_OVERRUN  = 2;
  localparam int STAT_TX_EMPTY = 3;

  localparam int CTRL_CPHA   = 0;
  localparam int CTRL_CPOL   = 1;
  localparam int CTRL_EN     = 2;
  localparam int CTRL_INT_EN = 3;

  localparam logic [7:0] TX_FILL = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } spi_state_e;

  // Leading edge is the idle->active SCLK transition for the given CPOL.
  function automatic logic lead_edge(input logic cpol, input logic rise, input logic fall);
    return cpol ? fall : rise;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_slave_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_slave_if : CPU register-access bus of the SPI slave.           |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
interface spi_slave_if;
  logic       i_en;
  logic       i_wr;
  logic [3:0] i_addr;
  logic [7:0] i_data;
  logic [7:0] o_data;

  modport master (output i_en, output i_wr, output i_addr, output i_data, input o_data);
  modport slave  (input i_en, input i_wr, input i_addr, input i_data, output o_data);
endinterface
`default_nettype wire

// File: rtl/spi_slave_sync_bits.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_bits : multi-bit flop-chain synchronizer with reset preset.    |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module sync_bits #(
  parameter int               WIDTH       = 1,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
  input  wire logic             clk_i,
  input  wire logic             rst_i,
  input  wire logic [WIDTH-1:0] d_i,
  output logic      [WIDTH-1:0] q_o
);

  // Fewer than two stages would not settle metastability.
  localparam int N_STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [WIDTH-1:0] stage_q [N_STAGES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < N_STAGES; s++) stage_q[s] <= RESET_VAL;
    end else begin
      stage_q[0] <= d_i;
      for (int s = 1; s < N_STAGES; s++) stage_q[s] <= stage_q[s-1];
    end
  end

  assign q_o = stage_q[N_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_slave : 8-bit SPI slave (modes 0-3) with CPU register access.   |
// | Optional interrupt output enabled by defining SPI_SLAVE_INT_EN.     |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  wire logic i_clk,
  input  wire logic i_rst,
  input  wire logic i_SCLK,
  input  wire logic i_MOSI,
  input  wire logic i_SS_bar,
  output logic      o_MISO,
  output logic      o_MISO_oe,
  output logic      o_int,
  spi_slave_if.slave cpu
);

`ifdef SPI_SLAVE_INT_EN
  localparam logic [3:0] CTRL_WMASK = 4'hF;
`else
  localparam logic [3:0] CTRL_WMASK = 4'h7;
`endif

  logic [2:0] sync_w;
  logic       sclk_s, mosi_s, ss_s;

  sync_bits #(
    .WIDTH      (3),
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (3'b100)
  ) u_sync (
    .clk_i(i_clk),
    .rst_i(i_rst),
    .d_i  ({i_SS_bar, i_MOSI, i_SCLK}),
    .q_o  (sync_w)
  );

  assign {ss_s, mosi_s, sclk_s} = sync_w;

  spi_state_e state_q;
  logic [3:0] ctrl_q;
  logic [7:0] data_in_q, tx_hold_q, tx_shift_q, rx_shift_q, rdata_q, rdata_d;
  logic       rx_full_q, overrun_q, tx_empty_q;
  logic [2:0] bit_cnt_q;
  logic       sclk_prev_q, ss_prev_q;

  logic sclk_rise, sclk_fall, ss_fall, lead, trail, sample_edge, shift_edge;
  logic enable, cpu_rd, cpu_wr, rd_data_in;
  logic [7:0] status_w;

  assign sclk_rise   = sclk_s & ~sclk_prev_q;
  assign sclk_fall   = ~sclk_s & sclk_prev_q;
  assign ss_fall     = ss_prev_q & ~ss_s;
  assign lead        = lead_edge(ctrl_q[CTRL_CPOL], sclk_rise, sclk_fall);
  assign trail       = lead_edge(ctrl_q[CTRL_CPOL], sclk_fall, sclk_rise);
  assign sample_edge = ctrl_q[CTRL_CPHA] ? trail : lead;
  assign shift_edge  = ctrl_q[CTRL_CPHA] ? lead : trail;

  assign enable     = ctrl_q[CTRL_EN];
  assign cpu_rd     = cpu.i_en & ~cpu.i_wr;
  assign cpu_wr     = cpu.i_en & cpu.i_wr;
  assign rd_data_in = cpu_rd && (cpu.i_addr == ADDR_DATA_IN);

  assign status_w = {4'b0000, tx_empty_q, overrun_q, rx_full_q, ~ss_s};

  always_comb begin
    rdata_d = 8'h00;
    case (cpu.i_addr)
      ADDR_STATUS:   rdata_d = status_w;
      ADDR_DATA_OUT: rdata_d = tx_hold_q;
      ADDR_DATA_IN:  rdata_d = data_in_q;
      ADDR_CTRL:     rdata_d = {4'b0000, ctrl_q};
      default:       rdata_d = 8'h00;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      ctrl_q      <= 4'h0;
      data_in_q   <= 8'h00;
      tx_hold_q   <= 8'h00;
      tx_shift_q  <= 8'h00;
      rx_shift_q  <= 8'h00;
      rdata_q     <= 8'h00;
      rx_full_q   <= 1'b0;
      overrun_q   <= 1'b0;
      tx_empty_q  <= 1'b1;
      bit_cnt_q   <= 3'd0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
    end else begin
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;

      if (cpu_rd) rdata_q <= rdata_d;
      if (rd_data_in) rx_full_q <= 1'b0;
      if (cpu_wr && cpu.i_addr == ADDR_STATUS && cpu.i_data[STAT_OVERRUN])
        overrun_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (ss_fall && enable) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          tx_shift_q <= tx_empty_q ? TX_FILL : tx_hold_q;
          tx_empty_q <= 1'b1;
          bit_cnt_q  <= 3'd0;
          state_q    <= ss_s ? ST_IDLE : ST_SHIFT;
        end
        ST_SHIFT: begin
          if (ss_s) begin
            state_q <= ST_IDLE;
          end else if (sample_edge) begin
            rx_shift_q <= {rx_shift_q[6:0], mosi_s};
            bit_cnt_q  <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= ST_DONE;
          end else if (shift_edge && bit_cnt_q != 3'd0) begin
            // The edge before the first sample of a byte must not shift:
            // the MSB loaded in LOAD is still being presented.
            tx_shift_q <= {tx_shift_q[6:0], 1'b0};
          end
        end
        ST_DONE: begin
          if (!rx_full_q || rd_data_in) begin
            data_in_q <= rx_shift_q;
            rx_full_q <= 1'b1;
          end else begin
            overrun_q <= 1'b1;
          end
          state_q <= ss_s ? ST_IDLE : ST_LOAD;
        end
        default: state_q <= ST_IDLE;
      endcase

      if (!enable) state_q <= ST_IDLE;

      // A CPU write to DATA_OUT wins over LOAD marking the buffer consumed.
      if (cpu_wr && cpu.i_addr == ADDR_DATA_OUT) begin
        tx_hold_q  <= cpu.i_data;
        tx_empty_q <= 1'b0;
      end
      if (cpu_wr && cpu.i_addr == ADDR_CTRL) ctrl_q <= cpu.i_data[3:0] & CTRL_WMASK;
    end
  end

  assign cpu.o_data = rdata_q;
  assign o_MISO_oe  = ~ss_s & enable;
  assign o_MISO     = o_MISO_oe & tx_shift_q[7];

`ifdef SPI_SLAVE_INT_EN
  logic int_q;
  always_ff @(posedge i_clk) begin
    if (i_rst) int_q <= 1'b0;
    else       int_q <= (rx_full_q | overrun_q) & ctrl_q[CTRL_INT_EN];
  end
  assign o_int = int_q;
`else
  assign o_int = 1'b0;
`endif

endmodule
`default_nettype wire
